axi_ram_responder: RTL and testbench



---
 rtl/axi_pkg.sv | 58 +++++
 rtl/axi_burst_addr_gen.sv | 41 ++++
 rtl/axi_ram_responder.sv | 196 +++++++++++++++++++
 tb/tb_axi_ram_responder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4 types for the mesh endpoints: burst/response encodings and the
// bundled request (mosi) / response (miso) channel structs.
package axi_pkg;

  localparam int unsigned AXI_DW   = 32;
  localparam int unsigned AXI_AW   = 16;
  localparam int unsigned AXI_IDW  = 5;
  localparam int unsigned AXI_IDRW = 5;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10,
    RSVD  = 2'b11
  } burst_t;

  typedef logic [1:0] resp_t;
  localparam resp_t OKAY   = 2'b00;
  localparam resp_t EXOKAY = 2'b01;
  localparam resp_t SLVERR = 2'b10;
  localparam resp_t DECERR = 2'b11;

  typedef struct packed {
    logic [AXI_IDW-1:0]  awid;
    logic [AXI_AW-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    burst_t              awburst;
    logic                awvalid;
    logic [AXI_DW-1:0]   wdata;
    logic [AXI_DW/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                bready;
    logic [AXI_IDRW-1:0] arid;
    logic [AXI_AW-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    burst_t              arburst;
    logic                arvalid;
    logic                rready;
  } axi_mosi_t;

  typedef struct packed {
    logic                awready;
    logic                wready;
    logic [AXI_IDW-1:0]  bid;
    resp_t               bresp;
    logic                bvalid;
    logic                arready;
    logic [AXI_IDRW-1:0] rid;
    logic [AXI_DW-1:0]   rdata;
    resp_t               rresp;
    logic                rlast;
    logic                rvalid;
  } axi_miso_t;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address and burst legality check for one AXI
// channel (FIXED/INCR/WRAP, step = 1 << size).
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned BYTES      = 4
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [2:0]            size,
  input  burst_t                burst,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  err
);

  localparam int unsigned SIZE_MAX = $clog2(BYTES);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [31:0]           boundary;
  logic                  wrap_len_ok;

  always_comb begin
    step        = ADDR_WIDTH'(1) << size;
    incr_addr   = addr + step;
    boundary    = ({24'd0, len} + 32'd1) << size;
    wrap_mask   = ADDR_WIDTH'(boundary - 32'd1);
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    err         = (32'(size) > SIZE_MAX) || (burst == RSVD) ||
                  ((burst == WRAP) && !wrap_len_ok);
    case (burst)
      FIXED:   next_addr = addr;
      INCR:    next_addr = incr_addr;
      WRAP:    next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default: next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi_ram_responder.sv
// AXI4 slave RAM endpoint: independent write (AW/W/B) and read (AR/R) FSMs,
// one outstanding burst each, sharing a simple dual-port word RAM.
module axi_ram_responder
  import axi_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH  = AXI_DW,
  parameter int unsigned ADDR_WIDTH      = AXI_AW,
  parameter int unsigned ID_W_WIDTH      = AXI_IDW,
  parameter int unsigned ID_R_WIDTH      = AXI_IDRW,
  parameter int unsigned MEM_DEPTH_WORDS = 256
) (
  input  logic      ACLK,
  input  logic      ARESETn,
  input  axi_mosi_t s_axi_i,
  output axi_miso_t s_axi_o
);

  localparam int unsigned BYTES = AXI_DATA_WIDTH / 8;
  localparam int unsigned OFFS  = $clog2(BYTES);
  localparam int unsigned IDXW  = $clog2(MEM_DEPTH_WORDS);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

  logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH_WORDS];

  // ---------------- write path ----------------
  w_state_t              w_state, w_next;
  logic                  awready_q, wready_q, bvalid_q;
  logic [ID_W_WIDTH-1:0] bid_q;
  logic [ADDR_WIDTH-1:0] waddr_q, wg_addr, wg_next;
  logic [7:0]            wlen_q, wbeat_q, wg_len;
  logic [2:0]            wsize_q, wg_size;
  burst_t                wburst_q, wg_burst;
  logic                  werr_q, wg_err;
  logic                  aw_hs, w_hs, b_hs, w_last_beat;

  assign aw_hs       = s_axi_i.awvalid & awready_q;
  assign w_hs        = s_axi_i.wvalid & wready_q;
  assign b_hs        = s_axi_i.bready & bvalid_q;
  assign w_last_beat = (wbeat_q == wlen_q);

  // In idle the generator checks the incoming AW fields so err can be latched at the handshake.
  assign wg_addr  = (w_state == W_IDLE) ? s_axi_i.awaddr  : waddr_q;
  assign wg_len   = (w_state == W_IDLE) ? s_axi_i.awlen   : wlen_q;
  assign wg_size  = (w_state == W_IDLE) ? s_axi_i.awsize  : wsize_q;
  assign wg_burst = (w_state == W_IDLE) ? s_axi_i.awburst : wburst_q;

  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .BYTES(BYTES)) u_wgen (
    .addr(wg_addr), .len(wg_len), .size(wg_size), .burst(wg_burst),
    .next_addr(wg_next), .err(wg_err)
  );

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) w_next = W_RESP;
      W_RESP:  if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Ready/valid are registered decodes of the next state so they read 0 while in reset.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state   <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wsize_q   <= '0;
      wburst_q  <= FIXED;
      wbeat_q   <= '0;
      werr_q    <= 1'b0;
    end else begin
      w_state   <= w_next;
      awready_q <= (w_next == W_IDLE);
      wready_q  <= (w_next == W_DATA);
      bvalid_q  <= (w_next == W_RESP);
      if (aw_hs) begin
        bid_q    <= s_axi_i.awid;
        waddr_q  <= s_axi_i.awaddr;
        wlen_q   <= s_axi_i.awlen;
        wsize_q  <= s_axi_i.awsize;
        wburst_q <= s_axi_i.awburst;
        wbeat_q  <= '0;
        werr_q   <= wg_err;
      end
      if (w_hs) begin
        if (s_axi_i.wlast != w_last_beat) werr_q <= 1'b1;
        if (!w_last_beat) begin
          wbeat_q <= wbeat_q + 8'd1;
          waddr_q <= wg_next;
        end
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_hs && !werr_q) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (s_axi_i.wstrb[b]) mem[waddr_q[OFFS +: IDXW]][8*b +: 8] <= s_axi_i.wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  r_state_t                  r_state, r_next;
  logic                      arready_q, rvalid_q, rlast_q;
  logic [ID_R_WIDTH-1:0]     rid_q;
  logic [AXI_DATA_WIDTH-1:0] rdata_q;
  logic [ADDR_WIDTH-1:0]     raddr_q, rg_addr, rg_next;
  logic [7:0]                rlen_q, rbeat_q, rg_len;
  logic [2:0]                rsize_q, rg_size;
  burst_t                    rburst_q, rg_burst;
  logic                      rerr_q, rg_err;
  logic                      ar_hs, r_hs;

  assign ar_hs = s_axi_i.arvalid & arready_q;
  assign r_hs  = s_axi_i.rready & rvalid_q;

  assign rg_addr  = (r_state == R_IDLE) ? s_axi_i.araddr  : raddr_q;
  assign rg_len   = (r_state == R_IDLE) ? s_axi_i.arlen   : rlen_q;
  assign rg_size  = (r_state == R_IDLE) ? s_axi_i.arsize  : rsize_q;
  assign rg_burst = (r_state == R_IDLE) ? s_axi_i.arburst : rburst_q;

  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .BYTES(BYTES)) u_rgen (
    .addr(rg_addr), .len(rg_len), .size(rg_size), .burst(rg_burst),
    .next_addr(rg_next), .err(rg_err)
  );

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_FETCH;
      R_FETCH: r_next = R_DATA;
      R_DATA:  if (r_hs) r_next = rlast_q ? R_IDLE : R_FETCH;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rsize_q   <= '0;
      rburst_q  <= FIXED;
      rbeat_q   <= '0;
      rerr_q    <= 1'b0;
    end else begin
      r_state   <= r_next;
      arready_q <= (r_next == R_IDLE);
      rvalid_q  <= (r_next == R_DATA);
      rlast_q   <= (r_next == R_DATA) && (rbeat_q == rlen_q);
      if (ar_hs) begin
        rid_q    <= s_axi_i.arid;
        raddr_q  <= s_axi_i.araddr;
        rlen_q   <= s_axi_i.arlen;
        rsize_q  <= s_axi_i.arsize;
        rburst_q <= s_axi_i.arburst;
        rbeat_q  <= '0;
        rerr_q   <= rg_err;
      end
      if (r_state == R_FETCH) rdata_q <= rerr_q ? '0 : mem[raddr_q[OFFS +: IDXW]];
      if (r_hs && !rlast_q) begin
        rbeat_q <= rbeat_q + 8'd1;
        raddr_q <= rg_next;
      end
    end
  end

  always_comb begin
    s_axi_o         = '0;
    s_axi_o.awready = awready_q;
    s_axi_o.wready  = wready_q;
    s_axi_o.bvalid  = bvalid_q;
    s_axi_o.bid     = bid_q;
    s_axi_o.bresp   = werr_q ? SLVERR : OKAY;
    s_axi_o.arready = arready_q;
    s_axi_o.rvalid  = rvalid_q;
    s_axi_o.rlast   = rlast_q;
    s_axi_o.rid     = rid_q;
    s_axi_o.rdata   = rdata_q;
    s_axi_o.rresp   = rerr_q ? SLVERR : OKAY;
  end

endmodule

// File: tb/tb_axi_ram_responder.sv
// Self-checking bench for axi_ram_responder: directed vector table, corner
// sequences and randomized bursts against a behavioural memory model.
module tb_axi_ram_responder;
  import axi_pkg::*;

  logic      ACLK = 1'b0;
  logic      ARESETn;
  axi_mosi_t s_axi_i;
  axi_miso_t s_axi_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] model_mem [256];
  logic [31:0] wdata_a   [256];
  logic [3:0]  wstrb_a   [256];
  logic [31:0] last_rdata;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [4:0]  id;
    logic [31:0] base;
    logic [3:0]  strb_b1;
    logic [1:0]  resp;
    bit          toggle;
  } vec_t;
  vec_t vecs [8];

  axi_ram_responder #(
    .AXI_DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_W_WIDTH(5), .ID_R_WIDTH(5), .MEM_DEPTH_WORDS(256)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .s_axi_i(s_axi_i), .s_axi_o(s_axi_o)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_err(logic [7:0] len, logic [2:0] size, logic [1:0] burst);
    return (size > 3'd2) || (burst == 2'b11) ||
           ((burst == 2'b10) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
  endfunction

  // Beat i of a burst, from the closed-form AXI address rules.
  function automatic logic [15:0] beat_addr(logic [15:0] addr, logic [7:0] len, logic [2:0] size,
                                           logic [1:0] burst, int i);
    int a     = int'(addr);
    int step  = 1 << size;
    int bound = (int'(len) + 1) * step;
    case (burst)
      2'b00:   return addr;
      2'b01:   return 16'(a + i * step);
      default: return 16'((a - (a % bound)) + ((a + i * step) % bound));
    endcase
  endfunction

  function automatic int widx(logic [15:0] a);
    return int'(a[9:2]);
  endfunction

  task automatic axi_write(input logic [4:0] id, input logic [15:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int wlast_at,
                           input int hold_b, input int stop_after, input logic [1:0] exp_resp);
    int t;
    bit err;
    err = model_err(len, size, burst);
    @(posedge ACLK); #1;
    s_axi_i.awid = id; s_axi_i.awaddr = addr; s_axi_i.awlen = len;
    s_axi_i.awsize = size; s_axi_i.awburst = burst_t'(burst); s_axi_i.awvalid = 1'b1;
    for (t = 0; t < 50; t++) begin @(negedge ACLK); if (s_axi_o.awready) break; end
    chk("aw_ready", 64'(t < 50), 1);
    @(posedge ACLK); #1;
    s_axi_i.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      s_axi_i.wdata = wdata_a[i]; s_axi_i.wstrb = wstrb_a[i];
      s_axi_i.wlast = (i == wlast_at); s_axi_i.wvalid = 1'b1;
      for (t = 0; t < 50; t++) begin @(negedge ACLK); if (s_axi_o.wready) break; end
      chk("w_ready_lat", 64'(t), 0);
      @(posedge ACLK); #1;
      if (!err)
        for (int b = 0; b < 4; b++)
          if (wstrb_a[i][b]) model_mem[widx(beat_addr(addr, len, size, burst, i))][8*b +: 8] = wdata_a[i][8*b +: 8];
      if (i + 1 == stop_after) begin
        s_axi_i.wvalid = 1'b0; s_axi_i.wlast = 1'b0;
        return;
      end
    end
    s_axi_i.wvalid = 1'b0; s_axi_i.wlast = 1'b0;
    @(negedge ACLK);
    chk("b_valid_lat", 64'(s_axi_o.bvalid), 1);
    chk("b_id", 64'(s_axi_o.bid), 64'(id));
    chk("b_resp", 64'(s_axi_o.bresp), 64'(exp_resp));
    chk("w_ready_closed", 64'(s_axi_o.wready), 0);
    for (int k = 0; k < hold_b; k++) begin
      @(negedge ACLK);
      chk("b_hold", 64'({s_axi_o.bvalid, s_axi_o.bid, s_axi_o.awready}), 64'({1'b1, id, 1'b0}));
    end
    s_axi_i.bready = 1'b1;
    @(posedge ACLK); #1;
    s_axi_i.bready = 1'b0;
    @(negedge ACLK);
    chk("b_done", 64'({s_axi_o.bvalid, s_axi_o.awready}), 64'(2'b01));
  endtask

  task automatic axi_read(input logic [4:0] id, input logic [15:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input bit toggle,
                          input logic [1:0] exp_resp);
    logic [31:0] exp_d [256];
    int t, n;
    bit err;
    err = model_err(len, size, burst);
    for (int i = 0; i <= int'(len); i++)
      exp_d[i] = err ? 32'd0 : model_mem[widx(beat_addr(addr, len, size, burst, i))];
    @(posedge ACLK); #1;
    s_axi_i.arid = id; s_axi_i.araddr = addr; s_axi_i.arlen = len;
    s_axi_i.arsize = size; s_axi_i.arburst = burst_t'(burst); s_axi_i.arvalid = 1'b1;
    for (t = 0; t < 50; t++) begin @(negedge ACLK); if (s_axi_o.arready) break; end
    chk("ar_ready", 64'(t < 50), 1);
    @(posedge ACLK); #1;
    s_axi_i.arvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      for (t = 0; t < 50; t++) begin @(negedge ACLK); if (s_axi_o.rvalid) break; end
      chk("r_valid_lat", 64'(t), 1);
      chk("r_data", 64'(s_axi_o.rdata), 64'(exp_d[i]));
      chk("r_id", 64'(s_axi_o.rid), 64'(id));
      chk("r_last", 64'(s_axi_o.rlast), 64'(i == int'(len)));
      chk("r_resp", 64'(s_axi_o.rresp), 64'(exp_resp));
      last_rdata = s_axi_o.rdata;
      n = toggle ? int'($urandom_range(0, 3)) : 0;
      for (int k = 0; k < n; k++) begin
        @(negedge ACLK);
        chk("r_hold", 64'({s_axi_o.rvalid, s_axi_o.rdata}), 64'({1'b1, exp_d[i]}));
      end
      s_axi_i.rready = 1'b1;
      @(posedge ACLK); #1;
      s_axi_i.rready = 1'b0;
    end
    @(negedge ACLK);
    chk("r_done", 64'({s_axi_o.rvalid, s_axi_o.arready}), 64'(2'b01));
  endtask

  initial begin
    logic [15:0] ra;
    logic [7:0]  rl;
    logic [2:0]  rs;
    logic [1:0]  rb;

    s_axi_i = '0;
    ARESETn = 1'b0;
    repeat (3) @(negedge ACLK);
    chk("rst_flags", 64'({s_axi_o.awready, s_axi_o.wready, s_axi_o.bvalid,
                          s_axi_o.arready, s_axi_o.rvalid, s_axi_o.rlast}), 0);
    chk("rst_fields", 64'({s_axi_o.bid, s_axi_o.bresp, s_axi_o.rid, s_axi_o.rresp}), 0);
    chk("rst_rdata", 64'(s_axi_o.rdata), 0);
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("post_rst_ready", 64'({s_axi_o.awready, s_axi_o.arready, s_axi_o.wready,
                               s_axi_o.bvalid, s_axi_o.rvalid}), 64'(5'b11000));

    // Known background in every word
    for (int i = 0; i < 256; i++) begin
      wdata_a[i] = 32'hA500_0000 | 32'(i);
      wstrb_a[i] = 4'hF;
    end
    axi_write(5'd0, 16'h0000, 8'd255, 3'd2, 2'b01, 255, 0, -1, OKAY);

    vecs[0] = '{16'h0010, 8'd0, 3'd2, 2'b01, 5'd3,  32'hDEADBEEF, 4'hF, OKAY,   1'b0};
    vecs[1] = '{16'h0020, 8'd3, 3'd2, 2'b01, 5'd4,  32'h1,        4'h5, OKAY,   1'b1};
    vecs[2] = '{16'h003C, 8'd3, 3'd2, 2'b10, 5'd5,  32'hA,        4'hF, OKAY,   1'b0};
    vecs[3] = '{16'h0040, 8'd3, 3'd2, 2'b00, 5'd6,  32'hA,        4'hF, OKAY,   1'b1};
    vecs[4] = '{16'h0050, 8'd0, 3'd3, 2'b01, 5'd7,  32'h1234,     4'hF, SLVERR, 1'b0};
    vecs[5] = '{16'h0060, 8'd2, 3'd2, 2'b10, 5'd8,  32'h77,       4'hF, SLVERR, 1'b1};
    vecs[6] = '{16'h0070, 8'd1, 3'd2, 2'b11, 5'd9,  32'h99,       4'hF, SLVERR, 1'b0};
    vecs[7] = '{16'h0082, 8'd1, 3'd1, 2'b01, 5'd10, 32'h55AA55AA, 4'h3, OKAY,   1'b1};
    for (int v = 0; v < 8; v++) begin
      for (int j = 0; j <= int'(vecs[v].len); j++) begin
        wdata_a[j] = vecs[v].base + 32'(j);
        wstrb_a[j] = (j == 1) ? vecs[v].strb_b1 : 4'hF;
      end
      axi_write(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst,
                int'(vecs[v].len), 0, -1, vecs[v].resp);
      axi_read(vecs[v].id + 5'd16, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst,
               vecs[v].toggle, vecs[v].resp);
    end

    axi_read(5'd1, 16'h0010, 8'd0, 3'd2, 2'b01, 1'b0, OKAY);
    chk("word_10", 64'(last_rdata), 64'h0000_0000_DEAD_BEEF);
    axi_read(5'd1, 16'h0024, 8'd0, 3'd2, 2'b01, 1'b0, OKAY);
    chk("strb5_word_24", 64'(last_rdata), 64'hA500_0002);
    axi_read(5'd1, 16'h0030, 8'd0, 3'd2, 2'b01, 1'b0, OKAY);
    chk("wrap_word_30", 64'(last_rdata), 64'hB);
    axi_read(5'd1, 16'h003C, 8'd0, 3'd2, 2'b01, 1'b0, OKAY);
    chk("wrap_word_3c", 64'(last_rdata), 64'hA);
    axi_read(5'd1, 16'h0040, 8'd0, 3'd2, 2'b01, 1'b0, OKAY);
    chk("fixed_word_40", 64'(last_rdata), 64'hD);
    axi_read(5'd1, 16'h0050, 8'd0, 3'd2, 2'b01, 1'b0, OKAY);
    chk("err_write_suppressed", 64'(last_rdata), 64'hA500_0014);

    // WLAST on beat 0 of a 2-beat burst; zero strobes keep RAM untouched either way
    wdata_a[0] = 32'hFFFF_0000; wdata_a[1] = 32'hFFFF_0001;
    wstrb_a[0] = 4'h0;          wstrb_a[1] = 4'h0;
    axi_write(5'd2, 16'h00C0, 8'd1, 3'd2, 2'b01, 0, 0, -1, SLVERR);

    // B backpressure for 5 cycles
    wdata_a[0] = 32'h0BAD_F00D; wstrb_a[0] = 4'hF;
    axi_write(5'd11, 16'h00D0, 8'd0, 3'd2, 2'b01, 0, 5, -1, OKAY);

    // AW and AR in the same cycle on the same word: read sees the old value
    wdata_a[0] = 32'h1111_2222; wstrb_a[0] = 4'hF;
    fork
      axi_write(5'd12, 16'h0010, 8'd0, 3'd2, 2'b01, 0, 0, -1, OKAY);
      axi_read(5'd13, 16'h0010, 8'd0, 3'd2, 2'b01, 1'b0, OKAY);
    join
    chk("rbw_old", 64'(last_rdata), 64'h0000_0000_DEAD_BEEF);
    axi_read(5'd14, 16'h0010, 8'd0, 3'd2, 2'b01, 1'b0, OKAY);
    chk("rbw_new", 64'(last_rdata), 64'h1111_2222);

    // Reset after two beats of an 8-beat write
    for (int j = 0; j < 8; j++) begin
      wdata_a[j] = 32'hC0DE_0000 + 32'(j);
      wstrb_a[j] = 4'hF;
    end
    axi_write(5'd4, 16'h0100, 8'd7, 3'd2, 2'b01, 7, 0, 2, OKAY);
    #2 ARESETn = 1'b0;
    #1 chk("rst_async", 64'({s_axi_o.awready, s_axi_o.wready, s_axi_o.bvalid,
                             s_axi_o.arready, s_axi_o.rvalid}), 0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("rst_recover", 64'({s_axi_o.awready, s_axi_o.wready, s_axi_o.bvalid}), 64'(3'b100));
    axi_read(5'd5, 16'h0100, 8'd1, 3'd2, 2'b01, 1'b0, OKAY);
    chk("rst_beat1_kept", 64'(last_rdata), 64'hC0DE_0001);
    axi_read(5'd5, 16'h0108, 8'd0, 3'd2, 2'b01, 1'b0, OKAY);
    chk("rst_beat2_absent", 64'(last_rdata), 64'hA500_0042);

    // Randomized bursts against the model
    for (int n = 0; n < 40; n++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      rs = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      rl = 8'($urandom_range(0, 7));
      if (rb == 2'b10 && $urandom_range(0, 4) != 0)
        case ($urandom_range(0, 3))
          0: rl = 8'd1;
          1: rl = 8'd3;
          2: rl = 8'd7;
          default: rl = 8'd15;
        endcase
      for (int j = 0; j <= int'(rl); j++) begin
        wdata_a[j] = $urandom;
        wstrb_a[j] = 4'($urandom);
      end
      axi_write(5'($urandom), ra, rl, rs, rb, int'(rl), 0, -1, model_err(rl, rs, rb) ? SLVERR : OKAY);
      axi_read(5'($urandom), ra, rl, rs, rb, 1'($urandom), model_err(rl, rs, rb) ? SLVERR : OKAY);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
